// File: rtl/funnel_data_4_2_if.sv
// Handshake bundle for funnel_data_4_2: config channel, 4-lane input word, two output lanes.
// The slave modport is the datapath's view; master is the environment driving it.
interface funnel_data_4_2_if #(
    parameter int unsigned WIDTH = 16
);
    logic                 t_cfg_req;
    logic                 t_cfg_ack;
    logic [1:0]           t_cfg_dat;
    logic                 t_0_req;
    logic                 t_0_ack;
    logic [4*WIDTH-1:0]   t_0_dat;
    logic                 i_0_req;
    logic                 i_0_ack;
    logic [WIDTH-1:0]     i_0_dat;
    logic                 i_1_req;
    logic                 i_1_ack;
    logic [WIDTH-1:0]     i_1_dat;
    logic                 busy;

    modport slave (
        input  t_cfg_req, t_cfg_dat, t_0_req, t_0_dat, i_0_ack, i_1_ack,
        output t_cfg_ack, t_0_ack, i_0_req, i_0_dat, i_1_req, i_1_dat, busy
    );

    modport master (
        output t_cfg_req, t_cfg_dat, t_0_req, t_0_dat, i_0_ack, i_1_ack,
        input  t_cfg_ack, t_0_ack, i_0_req, i_0_dat, i_1_req, i_1_dat, busy
    );
endinterface

// File: rtl/funnel_data_4_2.sv
// Buffers one 4-lane word and serialises it onto two output lanes in bit-reversed lane order,
// 4 beats on lane 0 (4:1) or 2 beats on both lanes (4:2), with zero-bubble reload.
module funnel_data_4_2 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    funnel_data_4_2_if.slave      bus
);
    localparam logic [1:0] Mode41 = 2'd1;
    localparam logic [1:0] Mode42 = 2'd2;

    logic [1:0]         mode_q,  mode_d;
    logic [1:0]         wmode_q, wmode_d;
    logic [1:0]         state_q, state_d;
    logic               full_q,  full_d;
    logic [4*WIDTH-1:0] buf_q,   buf_d;

    logic [WIDTH-1:0]   lane [4];
    logic [1:0]         sel;
    logic [1:0]         sel_hi;
    logic [1:0]         state_nx;
    logic               mode_ok;
    logic               progress;
    logic               last;
    logic               done;
    logic               load;
    logic               cfg_wr;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane[i] = buf_q[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        mode_ok  = (mode_q == Mode41) || (mode_q == Mode42);
        sel      = {state_q[0], state_q[1]};
        sel_hi   = sel + 2'd2;
        state_nx = state_q + wmode_q;
        last     = (state_nx == 2'd0);

        bus.i_0_req = full_q;
        bus.i_1_req = full_q && (wmode_q == Mode42);
        bus.i_0_dat = full_q ? lane[sel] : '0;
        // Lane 1 is unused in 4:1 and held at zero.
        bus.i_1_dat = bus.i_1_req ? lane[sel_hi] : '0;
        bus.busy    = full_q;

        unique case (wmode_q)
            Mode41:  progress = bus.i_0_req && bus.i_0_ack;
            Mode42:  progress = bus.i_0_req && bus.i_1_req && bus.i_0_ack && bus.i_1_ack;
            default: progress = 1'b0;
        endcase

        done          = full_q && progress && last;
        bus.t_0_ack   = mode_ok && (!full_q || done);
        bus.t_cfg_ack = !full_q;
        load          = bus.t_0_req && bus.t_0_ack;
        cfg_wr        = bus.t_cfg_req && bus.t_cfg_ack;
    end

    always_comb begin
        mode_d  = mode_q;
        wmode_d = wmode_q;
        state_d = state_q;
        full_d  = full_q;
        buf_d   = buf_q;

        if (cfg_wr) begin
            mode_d = bus.t_cfg_dat;
        end

        // The word captures the pre-write mode so a coincident cfg write affects the next word.
        if (load) begin
            buf_d   = bus.t_0_dat;
            wmode_d = mode_q;
            full_d  = 1'b1;
            state_d = 2'd0;
        end else if (done) begin
            full_d  = 1'b0;
            state_d = 2'd0;
        end else if (progress) begin
            state_d = state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q  <= 2'd0;
            wmode_q <= 2'd0;
            state_q <= 2'd0;
            full_q  <= 1'b0;
            buf_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            wmode_q <= wmode_d;
            state_q <= state_d;
            full_q  <= full_d;
            buf_q   <= buf_d;
        end
    end
endmodule

// File: tb/tb_funnel_data_4_2.sv
// Directed-vector bench for funnel_data_4_2: beat order, joint acks, reload, cfg stall, reset.
module tb_funnel_data_4_2;
    localparam int unsigned WIDTH = 16;

    localparam logic [15:0] A1 = 16'h0A01, B1 = 16'h0B02, C1 = 16'h0C03, D1 = 16'h0D04;
    localparam logic [15:0] A2 = 16'h1A11, B2 = 16'h1B12, C2 = 16'h1C13, D2 = 16'h1D14;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    logic [63:0] w1;
    logic [63:0] w2;

    funnel_data_4_2_if #(.WIDTH(WIDTH)) bus ();

    funnel_data_4_2 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then leave time for input changes before sampling.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic write_cfg(input logic [1:0] code);
        bus.t_cfg_req = 1'b1;
        bus.t_cfg_dat = code;
        tick();
        bus.t_cfg_req = 1'b0;
    endtask

    task automatic load_word(input logic [63:0] w);
        bus.t_0_req = 1'b1;
        bus.t_0_dat = w;
        tick();
        bus.t_0_req = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [15:0] e0, input logic [15:0] e1);
        settle();
        check_eq({tag, ".i0"}, 64'(bus.i_0_dat), 64'(e0));
        check_eq({tag, ".i1"}, 64'(bus.i_1_dat), 64'(e1));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        w1 = {D1, C1, B1, A1};
        w2 = {D2, C2, B2, A2};
        reset = 1'b1;
        bus.t_cfg_req = 1'b0;
        bus.t_cfg_dat = 2'd0;
        bus.t_0_req   = 1'b0;
        bus.t_0_dat   = '0;
        bus.i_0_ack   = 1'b0;
        bus.i_1_ack   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        settle();
        check_eq("rst.busy",    64'(bus.busy),      64'd0);
        check_eq("rst.i0req",   64'(bus.i_0_req),   64'd0);
        check_eq("rst.t0ack",   64'(bus.t_0_ack),   64'd0);
        check_eq("rst.cfgack",  64'(bus.t_cfg_ack), 64'd1);
        check_eq("rst.i0dat",   64'(bus.i_0_dat),   64'd0);

        // 4:1 drain: A, C, B, D on lane 0
        write_cfg(2'd1);
        settle();
        check_eq("m41.t0ack_empty", 64'(bus.t_0_ack), 64'd1);
        bus.i_0_ack = 1'b1;
        load_word(w1);
        beat("m41.b0", A1, 16'h0);
        check_eq("m41.b0.t0ack", 64'(bus.t_0_ack), 64'd0);
        check_eq("m41.b0.i1req", 64'(bus.i_1_req), 64'd0);
        tick(); beat("m41.b1", C1, 16'h0);
        check_eq("m41.b1.t0ack", 64'(bus.t_0_ack), 64'd0);
        tick(); beat("m41.b2", B1, 16'h0);
        check_eq("m41.b2.t0ack", 64'(bus.t_0_ack), 64'd0);
        tick(); beat("m41.b3", D1, 16'h0);
        check_eq("m41.b3.t0ack", 64'(bus.t_0_ack), 64'd1);
        check_eq("m41.b3.i1req", 64'(bus.i_1_req), 64'd0);
        tick(); settle();
        check_eq("m41.busy_end", 64'(bus.busy), 64'd0);

        // 4:2 drain: A/C then B/D
        write_cfg(2'd2);
        bus.i_1_ack = 1'b1;
        load_word(w1);
        beat("m42.b0", A1, C1);
        check_eq("m42.b0.i1req", 64'(bus.i_1_req), 64'd1);
        tick(); beat("m42.b1", B1, D1);
        check_eq("m42.b1.t0ack", 64'(bus.t_0_ack), 64'd1);
        tick(); settle();
        check_eq("m42.busy_end", 64'(bus.busy), 64'd0);

        // Lone ack on lane 0 must not advance
        bus.i_1_ack = 1'b0;
        load_word(w1);
        beat("lone.c0", A1, C1);
        tick(); beat("lone.c1", A1, C1);
        tick(); beat("lone.c2", A1, C1);
        bus.i_1_ack = 1'b1;
        tick(); beat("lone.adv", B1, D1);
        tick(); settle();
        check_eq("lone.busy_end", 64'(bus.busy), 64'd0);

        // Back-to-back words, no bubble
        bus.t_0_req = 1'b1;
        bus.t_0_dat = w1;
        tick();
        bus.t_0_dat = w2;
        beat("b2b.w1b0", A1, C1);
        check_eq("b2b.w1b0.t0ack", 64'(bus.t_0_ack), 64'd0);
        tick(); beat("b2b.w1b1", B1, D1);
        check_eq("b2b.w1b1.t0ack", 64'(bus.t_0_ack), 64'd1);
        tick();
        bus.t_0_req = 1'b0;
        beat("b2b.w2b0", A2, C2);
        check_eq("b2b.w2b0.busy", 64'(bus.busy), 64'd1);
        tick(); beat("b2b.w2b1", B2, D2);
        tick(); settle();
        check_eq("b2b.busy_end", 64'(bus.busy), 64'd0);

        // Cfg write stalled while busy; word drains in its own mode
        write_cfg(2'd1);
        load_word(w2);
        bus.t_cfg_req = 1'b1;
        bus.t_cfg_dat = 2'd2;
        beat("stall.b0", A2, 16'h0);
        check_eq("stall.cfgack", 64'(bus.t_cfg_ack), 64'd0);
        tick(); beat("stall.b1", C2, 16'h0);
        tick(); beat("stall.b2", B2, 16'h0);
        tick(); beat("stall.b3", D2, 16'h0);
        check_eq("stall.b3.cfgack", 64'(bus.t_cfg_ack), 64'd0);
        tick(); settle();
        check_eq("stall.busy_drop", 64'(bus.busy), 64'd0);
        check_eq("stall.cfgack_free", 64'(bus.t_cfg_ack), 64'd1);
        tick();
        bus.t_cfg_req = 1'b0;
        load_word(w1);
        beat("stall.new.b0", A1, C1);
        tick(); beat("stall.new.b1", B1, D1);
        tick(); settle();
        check_eq("stall.new.busy_end", 64'(bus.busy), 64'd0);

        // Reset in the middle of a 4:1 word
        write_cfg(2'd1);
        bus.i_1_ack = 1'b0;
        load_word(w1);
        beat("mid.b0", A1, 16'h0);
        tick(); beat("mid.b1", C1, 16'h0);
        tick(); beat("mid.b2", B1, 16'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        check_eq("mid.busy",  64'(bus.busy),    64'd0);
        check_eq("mid.i0req", 64'(bus.i_0_req), 64'd0);
        check_eq("mid.t0ack", 64'(bus.t_0_ack), 64'd0);
        write_cfg(2'd3);
        bus.t_0_req = 1'b1;
        bus.t_0_dat = w2;
        settle();
        check_eq("dis.t0ack", 64'(bus.t_0_ack), 64'd0);
        tick(); settle();
        check_eq("dis.busy", 64'(bus.busy), 64'd0);
        bus.t_0_req = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
